core_div_sequencer: RTL and testbench
=====================================

# core_div_sequencer

Multi-cycle sequencer for RV32M DIV/DIVU/REM/REMU in the EX stage. It runs a radix-2 restoring divider one quotient bit per cycle and stalls the pipeline while it computes. Divide-by-zero and signed overflow resolve without iterating. Completion is reported with a one-cycle result handshake to the EX/MEM result mux, beside the combinational multiplier.

## Interface
- XLEN, 32, operand/result width; counter width is clog2(XLEN).
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_valid  in  1  EX holds an OP (0110011) instruction with funct7 0000001.
- i_funct3  in  3  4=DIV, 5=DIVU, 6=REM, 7=REMU; 0-3 are ignored as not-divide.
- i_dividend  in  XLEN  forwarded rs1 value.
- i_divisor  in  XLEN  forwarded rs2 value.
- i_flush  in  1  kill the EX-stage instruction (branch/trap).
- i_hold  in  1  downstream cannot take the result this cycle.
- o_stall  out  1  freeze PC/IF/ID/EX (combinational).
- o_busy  out  1  registered; high in CALC.
- o_valid  out  1  registered; result valid.
- o_result  out  XLEN  registered; quotient or remainder.

## Operation
- Start condition: start = i_valid & i_funct3[2] & ~i_flush, evaluated in IDLE.
- States: IDLE, CALC, DONE.
- IDLE, start with a special case: latch op, go to DONE, and load o_result directly.
  - Divisor zero: quotient = all ones; remainder = dividend.
  - DIV/REM with dividend 0x80000000 and divisor 0xFFFFFFFF: quotient = 0x80000000; remainder = 0.
- IDLE, start otherwise: latch op.
  - Latch magnitudes |dividend| and |divisor| (abs only for DIV/REM).
  - Latch q_neg = sign(a) ^ sign(b) (signed ops) and r_neg = sign(a) (signed ops).
  - Clear remainder reg, set count = XLEN-1, go to CALC.
- CALC, each cycle:
  - {rem, quo} shifted left 1; trial = rem_shifted - divisor (XLEN+1 bits).
  - If trial is non-negative, rem = trial and quo[0] = 1; else quo[0] = 0.
  - count decrements.
  - At count == 0 the final iteration runs, o_result is loaded, and the state goes to DONE.
- Final result:
  - DIV/DIVU select quo; REM/REMU select rem.
  - Negate the quotient when q_neg; negate the remainder when r_neg (signed ops only).
- DONE: o_valid = 1 and o_stall = 0.
  - i_hold = 0: go to IDLE.
  - i_hold = 1: stay in DONE with o_valid and o_result held.
- o_stall = (IDLE & start) | CALC. It is 0 in DONE so the instruction retires that cycle.
- While i_rst is asserted, o_stall is forced 0.
- i_flush in any state: next state IDLE, o_busy = 0, o_valid = 0. The result is discarded and no start occurs that cycle.
- The instruction following the divide reaches EX in the cycle after DONE and is evaluated as a fresh start in IDLE. There is no back-to-back re-trigger of the retired op.
- Operand inputs are sampled only at the start edge. Changes during CALC are ignored.

## Timing
- Reset (asynchronous, immediate):
  - state = IDLE, o_valid = 0, o_busy = 0, o_result = 0.
  - Remainder, quotient and divisor registers and count = 0.
- Normal op, start accepted in cycle N:
  - CALC runs cycles N+1..N+XLEN.
  - o_valid is high in cycle N+XLEN+1 (N+33 for XLEN=32).
  - o_stall is high in cycles N..N+XLEN (33 cycles).
- Special case: o_valid in N+1; o_stall high only in N.
- o_busy is high exactly in the CALC cycles.
- o_valid is high for one cycle per accepted op, plus one per cycle of i_hold while in DONE.
- Reset mid-CALC: abort with no o_valid. The first start after reset release behaves normally.
- Flush and hold in the same DONE cycle: flush wins.
- Simultaneous i_valid and i_flush in IDLE: no start, o_stall = 0.

## Test plan
- DIVU 100 / 7, start at cycle N:
  - o_stall is high N..N+32.
  - o_valid in N+33 with o_result = 14.
  - REMU with the same operands gives 2.
- Signed ops:
  - DIV -7 / 2 gives 0xFFFFFFFD (-3).
  - REM -7 / 2 gives 0xFFFFFFFF (-1).
  - REM 7 / -2 gives 1.
- Divide by zero:
  - DIVU 0x1234 / 0 gives 0xFFFFFFFF in N+1.
  - REM 0x1234 / 0 gives 0x1234.
  - o_stall is high only in N.
- Overflow:
  - DIV 0x80000000 / 0xFFFFFFFF gives 0x80000000 in N+1.
  - REM with the same operands gives 0.
  - DIVU with the same operands iterates 33 cycles and gives 0.
- Flush / reset abort:
  - DIVU 1000/3 with i_flush at N+10: IDLE at N+11, no o_valid ever.
  - A new DIVU 9/3 started at N+12 gives 3 at N+45.
  - Repeat the abort with i_rst pulsed at N+10: outputs return to 0 immediately.
- Hold and non-divide:
  - DIVU 50/5 with i_hold high for 2 cycles at completion: o_valid = 1 and o_result = 10 for 3 cycles, then IDLE.
  - i_valid with funct3 = 0 (MUL) never asserts o_stall.

Source files
------------

// File: rtl/core_div_sequencer_if.sv
// ---------------------------------------------------------------------------
// core_div_sequencer_if
// Handshake bundle between the EX stage and the multi-cycle divide sequencer.
//   i_valid    : EX holds an RV32M divide-class OP instruction
//   i_funct3   : 4=DIV, 5=DIVU, 6=REM, 7=REMU (0-3 are not divides)
//   i_dividend : forwarded rs1
//   i_divisor  : forwarded rs2
//   i_flush    : kill the EX-stage instruction
//   i_hold     : downstream cannot take the result this cycle
//   o_stall    : freeze PC/IF/ID/EX (combinational)
//   o_busy     : high while iterating
//   o_valid    : result valid
//   o_result   : quotient or remainder
// slave modport = divider side, master modport = pipeline side.
// ---------------------------------------------------------------------------
interface core_div_sequencer_if #(
    parameter int XLEN = 32
) ();
    logic            i_valid;
    logic [2:0]      i_funct3;
    logic [XLEN-1:0] i_dividend;
    logic [XLEN-1:0] i_divisor;
    logic            i_flush;
    logic            i_hold;
    logic            o_stall;
    logic            o_busy;
    logic            o_valid;
    logic [XLEN-1:0] o_result;

    modport slave (
        input  i_valid, i_funct3, i_dividend, i_divisor, i_flush, i_hold,
        output o_stall, o_busy, o_valid, o_result
    );

    modport master (
        output i_valid, i_funct3, i_dividend, i_divisor, i_flush, i_hold,
        input  o_stall, o_busy, o_valid, o_result
    );
endinterface

// File: rtl/core_div_sequencer.sv
// ---------------------------------------------------------------------------
// core_div_sequencer
// Radix-2 restoring divider for DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Divide-by-zero and signed overflow resolve in one cycle without iterating.
// Ports:
//   i_clk : clock, rising edge
//   i_rst : asynchronous active-high reset
//   bus   : core_div_sequencer_if.slave (operands, flush/hold, stall/busy/
//           valid/result)
// ---------------------------------------------------------------------------
module core_div_sequencer #(
    parameter int XLEN = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    core_div_sequencer_if.slave  bus
);
    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0]   CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0]   CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]   CNT_LAST = {CW{1'b1}};
    localparam logic [XLEN-1:0] ZERO     = {XLEN{1'b0}};
    localparam logic [XLEN-1:0] ONE      = {{(XLEN-1){1'b0}}, 1'b1};
    localparam logic [XLEN-1:0] ONES     = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Two's-complement negate
    function automatic logic [XLEN-1:0] neg(input logic [XLEN-1:0] x);
        return (~x) + ONE;
    endfunction

    state_t          state_q, state_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] dvs_q, dvs_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            is_rem_q, is_rem_d;
    logic            q_neg_q, q_neg_d;
    logic            r_neg_q, r_neg_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            valid_q, valid_d;
    logic            busy_q, busy_d;

    logic            start_s;
    logic            signed_op_s;
    logic            div_zero_s;
    logic            ovf_s;
    logic [XLEN-1:0] a_abs_s;
    logic [XLEN-1:0] b_abs_s;
    logic [XLEN-1:0] special_s;
    logic [XLEN:0]   rem_sh_s;
    logic [XLEN:0]   trial_s;
    logic [XLEN-1:0] rem_nx_s;
    logic [XLEN-1:0] quo_nx_s;
    logic [XLEN-1:0] final_s;

    assign start_s     = bus.i_valid & bus.i_funct3[2] & ~bus.i_flush;
    // funct3[0] clear selects the signed variants (DIV/REM)
    assign signed_op_s = ~bus.i_funct3[0];
    assign div_zero_s  = (bus.i_divisor == ZERO);
    assign ovf_s       = signed_op_s & (bus.i_dividend == INT_MIN) & (bus.i_divisor == ONES);
    assign a_abs_s     = (signed_op_s & bus.i_dividend[XLEN-1]) ? neg(bus.i_dividend) : bus.i_dividend;
    assign b_abs_s     = (signed_op_s & bus.i_divisor[XLEN-1])  ? neg(bus.i_divisor)  : bus.i_divisor;
    // funct3[1] set selects the remainder variants
    assign special_s   = div_zero_s ? (bus.i_funct3[1] ? bus.i_dividend : ONES)
                                    : (bus.i_funct3[1] ? ZERO : INT_MIN);

    // One restoring step: shift {rem,quo} left, try subtracting the divisor
    // with a spare top bit so a borrow shows up as a negative trial.
    assign rem_sh_s = {rem_q, quo_q[XLEN-1]};
    assign trial_s  = rem_sh_s - {1'b0, dvs_q};
    assign rem_nx_s = trial_s[XLEN] ? rem_sh_s[XLEN-1:0] : trial_s[XLEN-1:0];
    assign quo_nx_s = {quo_q[XLEN-2:0], ~trial_s[XLEN]};
    assign final_s  = is_rem_q ? (r_neg_q ? neg(rem_nx_s) : rem_nx_s)
                               : (q_neg_q ? neg(quo_nx_s) : quo_nx_s);

    assign bus.o_stall  = ~i_rst & (((state_q == S_IDLE) & start_s) | (state_q == S_CALC));
    assign bus.o_busy   = busy_q;
    assign bus.o_valid  = valid_q;
    assign bus.o_result = result_q;

    // Next-state and datapath update for the IDLE/CALC/DONE sequencer
    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        cnt_d    = cnt_q;
        is_rem_d = is_rem_q;
        q_neg_d  = q_neg_q;
        r_neg_d  = r_neg_q;
        result_d = result_q;
        valid_d  = 1'b0;
        busy_d   = 1'b0;

        if (bus.i_flush) begin
            // Flush discards any in-flight or completed result
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_s) begin
                        is_rem_d = bus.i_funct3[1];
                        if (div_zero_s | ovf_s) begin
                            result_d = special_s;
                            state_d  = S_DONE;
                        end else begin
                            quo_d   = a_abs_s;
                            dvs_d   = b_abs_s;
                            rem_d   = ZERO;
                            cnt_d   = CNT_LAST;
                            q_neg_d = signed_op_s & (bus.i_dividend[XLEN-1] ^ bus.i_divisor[XLEN-1]);
                            r_neg_d = signed_op_s & bus.i_dividend[XLEN-1];
                            state_d = S_CALC;
                        end
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_CALC: begin
                    rem_d = rem_nx_s;
                    quo_d = quo_nx_s;
                    cnt_d = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ZERO) begin
                        result_d = final_s;
                        state_d  = S_DONE;
                    end else begin
                        state_d = S_CALC;
                    end
                end
                S_DONE: begin
                    if (bus.i_hold) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        valid_d = (state_d == S_DONE);
        busy_d  = (state_d == S_CALC);
    end

    // State and datapath registers, cleared asynchronously by reset
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= S_IDLE;
            rem_q    <= ZERO;
            quo_q    <= ZERO;
            dvs_q    <= ZERO;
            cnt_q    <= CNT_ZERO;
            is_rem_q <= 1'b0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            result_q <= ZERO;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            cnt_q    <= cnt_d;
            is_rem_q <= is_rem_d;
            q_neg_q  <= q_neg_d;
            r_neg_q  <= r_neg_d;
            result_q <= result_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
        end
    end
endmodule

// File: tb/tb_core_div_sequencer.sv
// ---------------------------------------------------------------------------
// tb_core_div_sequencer
// Self-checking bench for core_div_sequencer: directed vector table, flush,
// reset-abort, hold and non-divide sequences, then randomized operations
// checked against a plain-arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_core_div_sequencer;
    localparam int XLEN = 32;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    core_div_sequencer_if #(.XLEN(XLEN)) dif ();

    core_div_sequencer #(.XLEN(XLEN)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (dif.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
        int          hold;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    // Reference: RV32M semantics from plain arithmetic
    function automatic logic [31:0] ref_div(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        bit is_signed;
        bit is_rem;
        is_signed = (f3 == 3'd4) || (f3 == 3'd6);
        is_rem    = (f3 == 3'd6) || (f3 == 3'd7);
        sa = a;
        sb = b;
        if (b == 32'd0) return is_rem ? a : 32'hFFFF_FFFF;
        if (is_signed && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return is_rem ? 32'd0 : 32'h8000_0000;
        if (is_signed) return is_rem ? 32'(sa % sb) : 32'(sa / sb);
        return is_rem ? (a % b) : (a / b);
    endfunction

    function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        bit is_signed;
        is_signed = (f3 == 3'd4) || (f3 == 3'd6);
        if (b == 32'd0) return 1;
        if (is_signed && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // Issue one divide, follow it to completion, then through any hold cycles.
    task automatic do_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int lat, input int hold_n);
        int cyc;
        bit got;
        @(negedge clk);
        dif.i_valid    = 1'b1;
        dif.i_funct3   = f3;
        dif.i_dividend = a;
        dif.i_divisor  = b;
        dif.i_flush    = 1'b0;
        dif.i_hold     = 1'b0;
        #1;
        check({tag, "_stall_start"}, 32'(dif.o_stall), 32'd1);
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 40) begin
            @(negedge clk);
            cyc++;
            // EX keeps the instruction but operands are scrambled: must be ignored
            dif.i_dividend = $urandom;
            dif.i_divisor  = $urandom;
            #1;
            if (dif.o_valid) begin
                got = 1'b1;
            end else begin
                check({tag, "_stall_calc"}, 32'(dif.o_stall), 32'd1);
                check({tag, "_busy_calc"}, 32'(dif.o_busy), 32'd1);
            end
        end
        check({tag, "_latency"}, 32'(cyc), 32'(lat));
        if (got) begin
            check({tag, "_result"}, dif.o_result, exp);
            check({tag, "_stall_done"}, 32'(dif.o_stall), 32'd0);
            check({tag, "_busy_done"}, 32'(dif.o_busy), 32'd0);
            for (int k = 0; k < hold_n; k++) begin
                dif.i_hold = 1'b1;
                @(negedge clk);
                #1;
                check({tag, "_hold_valid"}, 32'(dif.o_valid), 32'd1);
                check({tag, "_hold_result"}, dif.o_result, exp);
            end
            dif.i_hold  = 1'b0;
            dif.i_valid = 1'b0;
            @(negedge clk);
            #1;
            check({tag, "_valid_after"}, 32'(dif.o_valid), 32'd0);
            check({tag, "_busy_after"}, 32'(dif.o_busy), 32'd0);
        end
    endtask

    // Start DIVU 1000/3 and run it to cycle N+10 (caller aborts there)
    task automatic start_and_run10(input string tag);
        @(negedge clk);
        dif.i_valid    = 1'b1;
        dif.i_funct3   = 3'd5;
        dif.i_dividend = 32'd1000;
        dif.i_divisor  = 32'd3;
        #1;
        check({tag, "_stall_start"}, 32'(dif.o_stall), 32'd1);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            #1;
            check({tag, "_busy"}, 32'(dif.o_busy), 32'd1);
            check({tag, "_valid"}, 32'(dif.o_valid), 32'd0);
        end
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        int          sel;

        vecs[0]  = '{3'd5, 32'd100,        32'd7,          32'd14,         33, 0};
        vecs[1]  = '{3'd7, 32'd100,        32'd7,          32'd2,          33, 0};
        vecs[2]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  33, 0};
        vecs[3]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  33, 0};
        vecs[4]  = '{3'd6, 32'd7,          32'hFFFF_FFFE,  32'd1,          33, 0};
        vecs[5]  = '{3'd5, 32'h0000_1234,  32'd0,          32'hFFFF_FFFF,  1,  0};
        vecs[6]  = '{3'd6, 32'h0000_1234,  32'd0,          32'h0000_1234,  1,  0};
        vecs[7]  = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1,  0};
        vecs[8]  = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1,  0};
        vecs[9]  = '{3'd5, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          33, 0};
        vecs[10] = '{3'd5, 32'd50,         32'd5,          32'd10,         33, 2};
        vecs[11] = '{3'd7, 32'hFFFF_FFFF,  32'd1,          32'd0,          33, 1};

        // Reset with a divide pending: stall must stay low, outputs zero
        rst            = 1'b1;
        dif.i_valid    = 1'b1;
        dif.i_funct3   = 3'd4;
        dif.i_dividend = 32'd10;
        dif.i_divisor  = 32'd3;
        dif.i_flush    = 1'b0;
        dif.i_hold     = 1'b0;
        #2;
        check("rst_stall", 32'(dif.o_stall), 32'd0);
        check("rst_valid", 32'(dif.o_valid), 32'd0);
        check("rst_busy", 32'(dif.o_busy), 32'd0);
        check("rst_result", dif.o_result, 32'd0);
        @(negedge clk);
        @(negedge clk);
        dif.i_valid = 1'b0;
        rst         = 1'b0;

        for (int i = 0; i < 12; i++) begin
            do_op($sformatf("vec%0d", i), vecs[i].f3, vecs[i].a, vecs[i].b,
                  vecs[i].exp, vecs[i].lat, vecs[i].hold);
        end

        // Flush at N+10: back to IDLE at N+11, never valid; new op at N+12
        start_and_run10("flush");
        dif.i_flush = 1'b1;
        dif.i_valid = 1'b0;
        #1;
        check("flush_valid_n10", 32'(dif.o_valid), 32'd0);
        @(negedge clk);
        dif.i_flush = 1'b0;
        #1;
        check("flush_busy_n11", 32'(dif.o_busy), 32'd0);
        check("flush_valid_n11", 32'(dif.o_valid), 32'd0);
        check("flush_stall_n11", 32'(dif.o_stall), 32'd0);
        do_op("after_flush", 3'd5, 32'd9, 32'd3, 32'd3, 33, 0);

        // Reset pulse at N+10: outputs drop immediately
        start_and_run10("rstab");
        rst = 1'b1;
        #1;
        check("rstab_busy", 32'(dif.o_busy), 32'd0);
        check("rstab_valid", 32'(dif.o_valid), 32'd0);
        check("rstab_result", dif.o_result, 32'd0);
        check("rstab_stall", 32'(dif.o_stall), 32'd0);
        @(negedge clk);
        dif.i_valid = 1'b0;
        rst         = 1'b0;
        #1;
        check("rstab_valid_n11", 32'(dif.o_valid), 32'd0);
        do_op("after_rst", 3'd5, 32'd9, 32'd3, 32'd3, 33, 0);

        // Non-divide (MUL) never stalls
        @(negedge clk);
        dif.i_valid    = 1'b1;
        dif.i_funct3   = 3'd0;
        dif.i_dividend = 32'd6;
        dif.i_divisor  = 32'd7;
        #1;
        check("mul_stall", 32'(dif.o_stall), 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            check("mul_stall_n", 32'(dif.o_stall), 32'd0);
            check("mul_busy_n", 32'(dif.o_busy), 32'd0);
            check("mul_valid_n", 32'(dif.o_valid), 32'd0);
        end

        // Valid and flush together in IDLE: no start
        dif.i_funct3 = 3'd5;
        dif.i_flush  = 1'b1;
        #1;
        check("vflush_stall", 32'(dif.o_stall), 32'd0);
        @(negedge clk);
        dif.i_flush = 1'b0;
        dif.i_valid = 1'b0;
        #1;
        check("vflush_busy", 32'(dif.o_busy), 32'd0);
        check("vflush_valid", 32'(dif.o_valid), 32'd0);

        // Randomized operations against the reference model
        for (int i = 0; i < 40; i++) begin
            f3  = 3'(4 + $urandom_range(0, 3));
            sel = $urandom_range(0, 7);
            a   = $urandom;
            b   = $urandom;
            if (sel == 0) begin
                b = 32'd0;
            end else if (sel == 1) begin
                a = 32'h8000_0000;
                b = 32'hFFFF_FFFF;
            end else if (sel <= 3) begin
                a = $urandom_range(0, 1000);
                b = $urandom_range(1, 20);
                if ($urandom_range(0, 1) == 1) a = (~a) + 32'd1;
                if ($urandom_range(0, 1) == 1) b = (~b) + 32'd1;
            end
            do_op($sformatf("rnd%0d", i), f3, a, b, ref_div(f3, a, b),
                  ref_lat(f3, a, b), $urandom_range(0, 2));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
